// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants, types and field helpers for the fetch stage
// Purpose: PC-select encodings, default reset/bubble words, per-edge action type,
//          and instruction field slicing shared by the fetch stage and its IF/ID register.
// Ports: none (package).
package if_stage_pkg;

  localparam logic [1:0]  PCSRC_SEQ = 2'b00;
  localparam logic [1:0]  PCSRC_RSV = 2'b01;
  localparam logic [1:0]  PCSRC_BR  = 2'b10;
  localparam logic [1:0]  PCSRC_J   = 2'b11;

  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DFLT = 32'h0000_0000;

  // What the stage does on the coming edge, in falling priority order.
  typedef enum logic [2:0] {
    ACT_REDIRECT,
    ACT_SQUASH,
    ACT_HOLD,
    ACT_MISS,
    ACT_FETCH
  } fetch_act_e;

  function automatic logic [5:0] inst_op(input logic [31:0] inst);
    return inst[31:26];
  endfunction

  function automatic logic [5:0] inst_func(input logic [31:0] inst);
    return inst[5:0];
  endfunction

  function automatic logic [4:0] inst_rs(input logic [31:0] inst);
    return inst[25:21];
  endfunction

  function automatic logic [4:0] inst_rt(input logic [31:0] inst);
    return inst[20:16];
  endfunction

  function automatic logic [4:0] inst_rd(input logic [31:0] inst);
    return inst[15:11];
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - bundle of fetch-stage control, memory and IF/ID signals
// Purpose: groups everything between the fetch stage and its neighbours.
// Ports (signals):
//   Pcsrc/BrTarget/JTarget, STALL/Condep      : next-PC select and decode hazards
//   ImemAddr/ImemRdata/ImemReady              : instruction memory
//   Pc, dInst/dPc4/dValid, Op/Func/Rs/Rt/Rd   : fetch PC and IF/ID contents
//   FetchCnt/StallCnt/FlushCnt                : saturating debug counters
// Modports: master = fetch stage, slave = surrounding pipeline / memory.
interface if_stage_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       Pcsrc;
  logic [31:0]      BrTarget;
  logic [31:0]      JTarget;
  logic             STALL;
  logic             Condep;
  logic [31:0]      ImemAddr;
  logic [31:0]      ImemRdata;
  logic             ImemReady;
  logic [31:0]      Pc;
  logic [31:0]      dInst;
  logic [31:0]      dPc4;
  logic             dValid;
  logic [5:0]       Op;
  logic [5:0]       Func;
  logic [4:0]       Rs;
  logic [4:0]       Rt;
  logic [4:0]       Rd;
  logic [CNT_W-1:0] FetchCnt;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    input  Pcsrc, BrTarget, JTarget, STALL, Condep, ImemRdata, ImemReady,
    output ImemAddr, Pc, dInst, dPc4, dValid, Op, Func, Rs, Rt, Rd,
           FetchCnt, StallCnt, FlushCnt
  );

  modport slave (
    output Pcsrc, BrTarget, JTarget, STALL, Condep, ImemRdata, ImemReady,
    input  ImemAddr, Pc, dInst, dPc4, dValid, Op, Func, Rs, Rt, Rd,
           FetchCnt, StallCnt, FlushCnt
  );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// rtl/if_stage_if_id_reg.sv - IF/ID pipeline register with load, hold and bubble
// Purpose: holds the instruction handed to decode together with its PC+4.
// Ports:
//   Clk, Rst            : clock, synchronous active-high reset
//   load_i, bubble_i    : load wins over bubble; neither = hold
//   inst_i, pc4_i       : word and its PC+4 to capture on load
//   dinst_o, dpc4_o     : registered instruction and PC+4
//   dvalid_o            : 1 = real instruction, 0 = bubble
module if_id_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] dinst_o,
  output logic [31:0] dpc4_o,
  output logic        dvalid_o
);
  logic [31:0] dinst_q, dinst_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic        dvalid_q, dvalid_d;

  // A bubble only replaces the word; dPc4 keeps its last value since it
  // carries no meaning while dValid is low.
  always_comb begin
    dinst_d  = dinst_q;
    dpc4_d   = dpc4_q;
    dvalid_d = dvalid_q;
    if (load_i) begin
      dinst_d  = inst_i;
      dpc4_d   = pc4_i;
      dvalid_d = 1'b1;
    end else if (bubble_i) begin
      dinst_d  = NOP_INST;
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      dinst_q  <= NOP_INST;
      dpc4_q   <= RESET_PC + 32'd4;
      dvalid_q <= 1'b0;
    end else begin
      dinst_q  <= dinst_d;
      dpc4_q   <= dpc4_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign dinst_o  = dinst_q;
  assign dpc4_o   = dpc4_q;
  assign dvalid_o = dvalid_q;
endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID register and event counters
// Purpose: holds the PC, chooses the next PC, captures fetched words into IF/ID,
//          honours decode's active-low STALL/Condep and counts fetch/stall/flush.
// Ports:
//   Clk  : clock, rising edge
//   Rst  : synchronous reset, active-high, overrides everything
//   bus  : if_stage_if.master (control, instruction memory, IF/ID, counters)
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DFLT,
  parameter logic [31:0] NOP_INST = NOP_INST_DFLT,
  parameter int          CNT_W    = 16
) (
  input  logic     Clk,
  input  logic     Rst,
  if_stage_if.master bus
);
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_plus4;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  fetch_act_e       act;
  logic             redirect;
  logic [31:0]      dinst;

  assign redirect = (bus.Pcsrc == PCSRC_BR) || (bus.Pcsrc == PCSRC_J);
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    if (redirect)          act = ACT_REDIRECT;
    else if (!bus.Condep)  act = ACT_SQUASH;
    else if (!bus.STALL)   act = ACT_HOLD;
    else if (!bus.ImemReady) act = ACT_MISS;
    else                   act = ACT_FETCH;
  end

  always_comb begin
    pc_d = pc_q;
    case (act)
      ACT_REDIRECT: pc_d = (bus.Pcsrc == PCSRC_J) ? bus.JTarget : bus.BrTarget;
      // A squash still lets the PC move on if the word was actually delivered.
      ACT_SQUASH:   if (bus.ImemReady && bus.STALL) pc_d = pc_plus4;
      ACT_FETCH:    pc_d = pc_plus4;
      default:      pc_d = pc_q;
    endcase
  end

  // Saturating counters: the increment is suppressed once all bits are set.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (act == ACT_FETCH && !(&fetch_cnt_q))
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    if ((act == ACT_HOLD || act == ACT_MISS) && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((act == ACT_REDIRECT || act == ACT_SQUASH) && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q        <= RESET_PC;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  if_id_reg #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) u_if_id (
    .Clk      (Clk),
    .Rst      (Rst),
    .load_i   (act == ACT_FETCH),
    .bubble_i (act == ACT_REDIRECT || act == ACT_SQUASH || act == ACT_MISS),
    .inst_i   (bus.ImemRdata),
    .pc4_i    (pc_plus4),
    .dinst_o  (dinst),
    .dpc4_o   (bus.dPc4),
    .dvalid_o (bus.dValid)
  );

  assign bus.ImemAddr = pc_q;
  assign bus.Pc       = pc_q;
  assign bus.dInst    = dinst;
  assign bus.Op       = inst_op(dinst);
  assign bus.Func     = inst_func(dinst);
  assign bus.Rs       = inst_rs(dinst);
  assign bus.Rt       = inst_rt(dinst);
  assign bus.Rd       = inst_rd(dinst);
  assign bus.FetchCnt = fetch_cnt_q;
  assign bus.StallCnt = stall_cnt_q;
  assign bus.FlushCnt = flush_cnt_q;
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage against a spec-level fetch model
module tb_if_stage;
  localparam int          CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  if_stage_if #(.CNT_W(CNT_W)) bus();

  if_stage #(.RESET_PC(RPC), .NOP_INST(NOP), .CNT_W(CNT_W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] dinst;
    logic [31:0] dpc4;
    logic        dvalid;
    logic        pc4_known;
    int          fc, sc, flc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Architectural view of the stage, updated one edge at a time.
  logic [31:0] m_pc = RPC, m_dinst = NOP, m_dpc4 = RPC + 32'd4;
  logic        m_dvalid = 1'b0, m_known = 1'b1;
  int          m_fc = 0, m_sc = 0, m_flc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and record what the stage must look like after the edge.
  task automatic step(input bit rst, input logic [1:0] src, input logic [31:0] br,
                      input logic [31:0] jt, input bit stall_n, input bit condep_n,
                      input bit rdy);
    exp_t e;
    @(negedge Clk);
    Rst = rst;
    bus.Pcsrc = src;
    bus.BrTarget = br;
    bus.JTarget = jt;
    bus.STALL = stall_n;
    bus.Condep = condep_n;
    bus.ImemReady = rdy;
    bus.ImemRdata = rdy ? mem_word(m_pc) : 32'hDEAD_BEEF;
    if (rst) begin
      m_pc = RPC; m_dinst = NOP; m_dpc4 = RPC + 32'd4; m_dvalid = 0; m_known = 1;
      m_fc = 0; m_sc = 0; m_flc = 0;
    end else if (src == 2'b10 || src == 2'b11) begin
      m_pc = (src == 2'b11) ? jt : br;
      m_dinst = NOP; m_dvalid = 0; m_known = 0; m_flc = sat(m_flc);
    end else if (!condep_n) begin
      if (rdy && stall_n) m_pc = m_pc + 32'd4;
      m_dinst = NOP; m_dvalid = 0; m_known = 0; m_flc = sat(m_flc);
    end else if (!stall_n) begin
      m_sc = sat(m_sc);
    end else if (!rdy) begin
      m_dinst = NOP; m_dvalid = 0; m_known = 0; m_sc = sat(m_sc);
    end else begin
      m_dinst = mem_word(m_pc); m_dpc4 = m_pc + 32'd4; m_dvalid = 1; m_known = 1;
      m_pc = m_pc + 32'd4; m_fc = sat(m_fc);
    end
    e.pc = m_pc; e.dinst = m_dinst; e.dpc4 = m_dpc4; e.dvalid = m_dvalid;
    e.pc4_known = m_known; e.fc = m_fc; e.sc = m_sc; e.flc = m_flc;
    exp_q.push_back(e);
  endtask

  task automatic fetch(input int n);
    for (int i = 0; i < n; i++) step(0, 2'b00, 0, 0, 1, 1, 1);
  endtask

  // Monitor: the stage presents a new state after every edge; compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("Pc", bus.Pc, e.pc);
        check("ImemAddr", bus.ImemAddr, e.pc);
        check("dInst", bus.dInst, e.dinst);
        check("dValid", 32'(bus.dValid), 32'(e.dvalid));
        if (e.pc4_known || e.dvalid) check("dPc4", bus.dPc4, e.dpc4);
        check("fields", {10'd0, bus.Op, bus.Rs, bus.Rt, bus.Rd, bus.Func},
              {10'd0, e.dinst[31:11], e.dinst[5:0]});
        check("FetchCnt", 32'(bus.FetchCnt), 32'(e.fc));
        check("StallCnt", 32'(bus.StallCnt), 32'(e.sc));
        check("FlushCnt", 32'(bus.FlushCnt), 32'(e.flc));
      end
    end
  end

  initial begin
    int guard;
    bus.Pcsrc = 2'b00; bus.BrTarget = '0; bus.JTarget = '0;
    bus.STALL = 1'b1; bus.Condep = 1'b1; bus.ImemReady = 1'b1; bus.ImemRdata = '0;

    // Reset then W0, W1, ... up to Pc=0x10
    step(1, 2'b00, 0, 0, 1, 1, 1);
    step(1, 2'b00, 0, 0, 1, 1, 1);
    fetch(4);
    // Load-use hold for three cycles, then release
    for (int i = 0; i < 3; i++) step(0, 2'b00, 0, 0, 0, 1, 1);
    fetch(2);
    // Branch at Pc=0x18 to 0x40
    step(0, 2'b10, 32'h40, 32'h0, 1, 1, 1);
    fetch(2);
    // Jump to 0x80 with a simultaneous stall: redirect wins
    step(0, 2'b11, 32'h0, 32'h80, 0, 1, 1);
    fetch(1);
    // Memory miss for two cycles at Pc=0x24
    step(0, 2'b11, 32'h0, 32'h24, 1, 1, 1);
    step(0, 2'b00, 0, 0, 1, 1, 0);
    step(0, 2'b00, 0, 0, 1, 1, 0);
    fetch(2);
    // Condep squash with and without a delivered word, and reserved Pcsrc
    step(0, 2'b00, 0, 0, 1, 0, 1);
    step(0, 2'b00, 0, 0, 1, 0, 0);
    step(0, 2'b01, 32'h100, 32'h200, 1, 1, 1);
    // PC wrap past the top of the address space
    step(0, 2'b11, 32'h0, 32'hFFFF_FFF8, 1, 1, 1);
    fetch(3);
    // Randomised traffic; long enough to drive every counter into saturation
    for (int i = 0; i < 400; i++) begin
      logic [31:0] br, jt;
      logic [1:0]  src;
      int          r;
      r   = $urandom_range(0, 99);
      src = (r < 6) ? 2'b10 : (r < 12) ? 2'b11 : (r < 16) ? 2'b01 : 2'b00;
      br  = $urandom() & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'h0000_0FFC);
      jt  = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 19) == 0) jt = 32'hFFFF_FFFC;
      step(($urandom_range(0, 299) == 0), src, br, jt,
           ($urandom_range(0, 99) >= 15), ($urandom_range(0, 99) >= 10),
           ($urandom_range(0, 99) >= 15));
    end
    // Reset in the middle of a stall clears everything in one edge
    step(0, 2'b00, 0, 0, 0, 1, 1);
    step(1, 2'b00, 0, 0, 0, 1, 1);
    step(0, 2'b00, 0, 0, 0, 1, 1);
    fetch(2);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge Clk);
      guard++;
    end
    #2;
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
